// File: rtl/dmem_timer_if.sv
// Datapath-to-data-memory bus: address, store data, size and direction in; load data and fault flags out.
// Latency: purely combinational bundle; no storage.
// Backpressure: none, every access completes in its own cycle.
interface dmem_timer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] addr_Dmem;
  logic [DATA_WIDTH-1:0] DataW_Dmem;
  logic                  MemRW;
  logic [2:0]            Funct3;
  logic [DATA_WIDTH-1:0] DataR;
  logic                  misaligned;
  logic                  access_fault;

  // Datapath side drives the request and observes the response.
  modport master (
    output addr_Dmem, DataW_Dmem, MemRW, Funct3,
    input  DataR, misaligned, access_fault
  );

  // Memory side consumes the request and produces the response.
  modport slave (
    input  addr_Dmem, DataW_Dmem, MemRW, Funct3,
    output DataR, misaligned, access_fault
  );
endinterface

// File: rtl/dmem_timer.sv
// Data-memory stage: word RAM with RISC-V B/H/W load-store semantics plus a memory-mapped 64-bit machine timer.
// Latency: loads return combinationally in the same cycle; stores and timer updates commit at the rising edge.
// Backpressure: none; faulting or misaligned accesses are dropped (no write, DataR = 0).
module dmem_timer #(
  parameter int                          DATA_WIDTH         = 32,
  parameter int                          DATAMEM_ADDR_WIDTH = 32,
  parameter int                          DEPTH_WORDS        = 1024,
  parameter logic [DATAMEM_ADDR_WIDTH-1:0] MMIO_BASE        = 32'hFFFF_0000
) (
  input  logic         clk,
  input  logic         reset_n,
  dmem_timer_if.slave  bus,
  output logic         timer_irq
);

  localparam int AW    = DATAMEM_ADDR_WIDTH;
  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] RAM_LIMIT = AW'(4 * DEPTH_WORDS);
  localparam logic [AW-1:0] MMIO_SPAN = AW'(24);

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // RAM storage; deliberately has no reset so contents survive reset_n.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  // Timer register file.
  logic [63:0] r_mtime;
  logic [63:0] r_mtimecmp;
  logic [1:0]  r_ctrl;
  logic        r_pending;

  logic [AW-1:0]         w_addr;
  logic [DATA_WIDTH-1:0] w_wdat_in;
  logic [2:0]            w_f3;
  logic [AW-1:0]         w_off;
  logic                  w_ram_hit;
  logic                  w_mmio_hit;
  logic                  w_mis;
  logic                  w_fault;
  logic                  w_ok;
  logic [IDX_W-1:0]      w_idx;
  logic [DATA_WIDTH-1:0] w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [DATA_WIDTH-1:0] w_ram_rd;
  logic [DATA_WIDTH-1:0] w_mmio_rd;
  logic [3:0]            w_be;
  logic [DATA_WIDTH-1:0] w_lane_dat;
  logic [DATA_WIDTH-1:0] w_merged;
  logic                  w_ram_we;
  logic                  w_mmio_we;
  logic                  w_wr_mtime_lo;
  logic                  w_wr_mtime_hi;
  logic                  w_wr_cmp_lo;
  logic                  w_wr_cmp_hi;
  logic                  w_wr_ctrl;
  logic                  w_clr_pending;
  logic                  w_cmp_ge;

  assign w_addr    = bus.addr_Dmem;
  assign w_wdat_in = bus.DataW_Dmem;
  assign w_f3      = bus.Funct3;

  // Address decode: RAM at the bottom of the map, six timer words at MMIO_BASE.
  assign w_off      = w_addr - MMIO_BASE;
  assign w_ram_hit  = (w_addr < RAM_LIMIT);
  assign w_mmio_hit = (w_addr >= MMIO_BASE) && (w_off < MMIO_SPAN);
  assign w_idx      = w_addr[IDX_W+1:2];
  assign w_word     = r_mem[w_idx];

  // Alignment and illegal-size check; this outranks the address fault.
  always_comb begin
    w_mis = 1'b0;
    case (w_f3)
      F3_B, F3_BU: w_mis = 1'b0;
      F3_H, F3_HU: w_mis = w_addr[0];
      F3_W:        w_mis = (w_addr[1:0] != 2'b00);
      default:     w_mis = 1'b1;
    endcase
  end

  assign w_fault = !w_mis && (!(w_ram_hit || w_mmio_hit) || (w_mmio_hit && (w_f3 != F3_W)));
  assign w_ok    = !w_mis && !w_fault;

  assign bus.misaligned   = w_mis;
  assign bus.access_fault = w_fault;

  // RAM load path: lane select then sign/zero extension by access size.
  always_comb begin
    w_byte   = w_word[8*w_addr[1:0] +: 8];
    w_half   = w_addr[1] ? w_word[31:16] : w_word[15:0];
    w_ram_rd = '0;
    case (w_f3)
      F3_B:    w_ram_rd = {{24{w_byte[7]}}, w_byte};
      F3_BU:   w_ram_rd = {24'd0, w_byte};
      F3_H:    w_ram_rd = {{16{w_half[15]}}, w_half};
      F3_HU:   w_ram_rd = {16'd0, w_half};
      F3_W:    w_ram_rd = w_word;
      default: w_ram_rd = '0;
    endcase
  end

  // Timer register read mux; unused bits and offsets read as zero.
  always_comb begin
    w_mmio_rd = '0;
    case (w_off[4:2])
      3'd0:    w_mmio_rd = r_mtime[31:0];
      3'd1:    w_mmio_rd = r_mtime[63:32];
      3'd2:    w_mmio_rd = r_mtimecmp[31:0];
      3'd3:    w_mmio_rd = r_mtimecmp[63:32];
      3'd4:    w_mmio_rd = {30'd0, r_ctrl};
      3'd5:    w_mmio_rd = {31'd0, r_pending};
      default: w_mmio_rd = '0;
    endcase
  end

  assign bus.DataR = !w_ok      ? '0 :
                     w_ram_hit  ? w_ram_rd : w_mmio_rd;

  // Store byte enables and lane-replicated store data for B/H/W.
  always_comb begin
    w_be       = 4'b0000;
    w_lane_dat = w_wdat_in;
    case (w_f3)
      F3_B, F3_BU: begin
        w_be       = 4'b0001 << w_addr[1:0];
        w_lane_dat = {4{w_wdat_in[7:0]}};
      end
      F3_H, F3_HU: begin
        w_be       = w_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_dat = {2{w_wdat_in[15:0]}};
      end
      F3_W: begin
        w_be       = 4'b1111;
        w_lane_dat = w_wdat_in;
      end
      default: begin
        w_be       = 4'b0000;
        w_lane_dat = w_wdat_in;
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      w_merged[8*i +: 8] = w_be[i] ? w_lane_dat[8*i +: 8] : w_word[8*i +: 8];
    end
  end

  assign w_ram_we  = bus.MemRW && w_ok && w_ram_hit;
  assign w_mmio_we = bus.MemRW && w_ok && w_mmio_hit;

  assign w_wr_mtime_lo = w_mmio_we && (w_off[4:2] == 3'd0);
  assign w_wr_mtime_hi = w_mmio_we && (w_off[4:2] == 3'd1);
  assign w_wr_cmp_lo   = w_mmio_we && (w_off[4:2] == 3'd2);
  assign w_wr_cmp_hi   = w_mmio_we && (w_off[4:2] == 3'd3);
  assign w_wr_ctrl     = w_mmio_we && (w_off[4:2] == 3'd4);
  assign w_clr_pending = w_mmio_we && (w_off[4:2] == 3'd5) && w_wdat_in[0];

  assign w_cmp_ge = (r_mtime >= r_mtimecmp);

  // RAM write: read-modify-write of the addressed word keeps untouched lanes.
  always_ff @(posedge clk) begin
    if (w_ram_we) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // mtime: software writes to either half take precedence over the increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtime <= 64'd0;
    end else if (w_wr_mtime_lo) begin
      r_mtime <= {r_mtime[63:32], w_wdat_in};
    end else if (w_wr_mtime_hi) begin
      r_mtime <= {w_wdat_in, r_mtime[31:0]};
    end else if (r_ctrl[0]) begin
      r_mtime <= r_mtime + 64'd1;
    end
  end

  // mtimecmp and CTRL: plain software-written registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      r_ctrl     <= 2'b00;
    end else begin
      if (w_wr_cmp_lo) r_mtimecmp[31:0]  <= w_wdat_in;
      if (w_wr_cmp_hi) r_mtimecmp[63:32] <= w_wdat_in;
      if (w_wr_ctrl)   r_ctrl            <= w_wdat_in[1:0];
    end
  end

  // Sticky pending flag; a compare hit in the same cycle beats a software clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_cmp_ge || (r_pending && !w_clr_pending);
    end
  end

  assign timer_irq = r_pending & r_ctrl[1];

endmodule

// File: tb/tb_dmem_timer.sv
// Directed bench for dmem_timer: table of load/store vectors plus hand-written timer and reset sequences.
// Inputs change 1 time unit after the rising edge; outputs are sampled mid-cycle.
// The design never stalls, so every step advances by a fixed number of edges.
module tb_dmem_timer;

  localparam logic [31:0] MB       = 32'hFFFF_0000;
  localparam logic [31:0] MTIME_LO = MB + 32'h00;
  localparam logic [31:0] MTIME_HI = MB + 32'h04;
  localparam logic [31:0] CMP_LO   = MB + 32'h08;
  localparam logic [31:0] CMP_HI   = MB + 32'h0C;
  localparam logic [31:0] CTRL     = MB + 32'h10;
  localparam logic [31:0] STATUS   = MB + 32'h14;

  logic clk;
  logic reset_n;
  logic timer_irq;

  int checks;
  int errors;

  dmem_timer_if u_if ();

  dmem_timer u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (u_if.slave),
    .timer_irq (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] ed;
    logic        em;
    logic        ef;
    logic        cd;
  } vec_t;

  vec_t tbl [33];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", nm, act, exp);
    end
  endtask

  task automatic idle();
    u_if.MemRW      = 1'b0;
    u_if.Funct3     = 3'b010;
    u_if.addr_Dmem  = 32'h0;
    u_if.DataW_Dmem = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    u_if.MemRW      = 1'b1;
    u_if.Funct3     = 3'b010;
    u_if.addr_Dmem  = a;
    u_if.DataW_Dmem = d;
    tick();
  endtask

  task automatic ld(input string nm, input logic [31:0] a, input logic [31:0] exp);
    u_if.MemRW     = 1'b0;
    u_if.Funct3    = 3'b010;
    u_if.addr_Dmem = a;
    #1;
    chk(nm, u_if.DataR, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] ed,
                              input logic em, input logic ef, input logic cd);
    vec_t v;
    v.we = we; v.f3 = f3; v.a = a; v.wd = wd; v.ed = ed; v.em = em; v.ef = ef; v.cd = cd;
    return v;
  endfunction

  initial begin
    checks = 0;
    errors = 0;

    //            we  f3    addr          wdata         expDataR      mis  flt  chkData
    tbl[0]  = mk(1, 3'd2, 32'h10,        32'h8070_F0A5, 32'h0,        0, 0, 0);
    tbl[1]  = mk(0, 3'd0, 32'h10,        32'h0,         32'hFFFF_FFA5, 0, 0, 1);
    tbl[2]  = mk(0, 3'd4, 32'h13,        32'h0,         32'h0000_0080, 0, 0, 1);
    tbl[3]  = mk(0, 3'd1, 32'h12,        32'h0,         32'hFFFF_8070, 0, 0, 1);
    tbl[4]  = mk(0, 3'd5, 32'h10,        32'h0,         32'h0000_F0A5, 0, 0, 1);
    tbl[5]  = mk(0, 3'd0, 32'h11,        32'h0,         32'hFFFF_FFF0, 0, 0, 1);
    tbl[6]  = mk(0, 3'd4, 32'h12,        32'h0,         32'h0000_0070, 0, 0, 1);
    tbl[7]  = mk(1, 3'd0, 32'h11,        32'hAABB_CC11, 32'h0,        0, 0, 0);
    tbl[8]  = mk(0, 3'd2, 32'h10,        32'h0,         32'h8070_11A5, 0, 0, 1);
    tbl[9]  = mk(1, 3'd1, 32'h12,        32'h1234_BEEF, 32'h0,        0, 0, 0);
    tbl[10] = mk(0, 3'd2, 32'h10,        32'h0,         32'hBEEF_11A5, 0, 0, 1);
    tbl[11] = mk(0, 3'd2, 32'h02,        32'h0,         32'h0,        1, 0, 1);
    tbl[12] = mk(1, 3'd2, 32'h04,        32'h1122_3344, 32'h0,        0, 0, 0);
    tbl[13] = mk(1, 3'd1, 32'h05,        32'h0000_DEAD, 32'h0,        1, 0, 1);
    tbl[14] = mk(0, 3'd2, 32'h04,        32'h0,         32'h1122_3344, 0, 0, 1);
    tbl[15] = mk(0, 3'd2, 32'h0001_0000, 32'h0,         32'h0,        0, 1, 1);
    tbl[16] = mk(0, 3'd0, MB,            32'h0,         32'h0,        0, 1, 1);
    tbl[17] = mk(0, 3'd3, 32'h10,        32'h0,         32'h0,        1, 0, 1);
    tbl[18] = mk(0, 3'd6, 32'h10,        32'h0,         32'h0,        1, 0, 1);
    tbl[19] = mk(0, 3'd1, 32'h0001_0001, 32'h0,         32'h0,        1, 0, 1);
    tbl[20] = mk(1, 3'd2, 32'hFFC,       32'hCAFE_BABE, 32'h0,        0, 0, 0);
    tbl[21] = mk(0, 3'd2, 32'hFFC,       32'h0,         32'hCAFE_BABE, 0, 0, 1);
    tbl[22] = mk(0, 3'd2, 32'h1000,      32'h0,         32'h0,        0, 1, 1);
    tbl[23] = mk(0, 3'd2, MB + 32'h18,   32'h0,         32'h0,        0, 1, 1);
    tbl[24] = mk(0, 3'd2, MB - 32'h4,    32'h0,         32'h0,        0, 1, 1);
    tbl[25] = mk(0, 3'd2, CMP_HI,        32'h0,         32'hFFFF_FFFF, 0, 0, 1);
    tbl[26] = mk(0, 3'd2, CMP_LO,        32'h0,         32'hFFFF_FFFF, 0, 0, 1);
    tbl[27] = mk(0, 3'd2, MTIME_LO,      32'h0,         32'h0,        0, 0, 1);
    tbl[28] = mk(1, 3'd0, CTRL,          32'hFFFF_FFFF, 32'h0,        0, 1, 1);
    tbl[29] = mk(0, 3'd2, CTRL,          32'h0,         32'h0,        0, 0, 1);
    tbl[30] = mk(0, 3'd2, STATUS,        32'h0,         32'h0,        0, 0, 1);
    tbl[31] = mk(0, 3'd2, MB + 32'h2,    32'h0,         32'h0,        1, 0, 1);
    tbl[32] = mk(0, 3'd4, 32'hFFF,       32'h0,         32'h0000_00CA, 0, 0, 1);

    idle();
    reset_n = 1'b0;
    #12;
    chk("reset_irq", {31'd0, timer_irq}, 32'h0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Table-driven load/store/fault vectors, one per cycle.
    for (int i = 0; i < 33; i++) begin
      u_if.MemRW      = tbl[i].we;
      u_if.Funct3     = tbl[i].f3;
      u_if.addr_Dmem  = tbl[i].a;
      u_if.DataW_Dmem = tbl[i].wd;
      #2;
      chk($sformatf("vec%0d_mis", i), {31'd0, u_if.misaligned}, {31'd0, tbl[i].em});
      chk($sformatf("vec%0d_fault", i), {31'd0, u_if.access_fault}, {31'd0, tbl[i].ef});
      if (tbl[i].cd) chk($sformatf("vec%0d_data", i), u_if.DataR, tbl[i].ed);
      tick();
    end

    // Compare and interrupt: mtime counts from 0, cmp = 20.
    store(CMP_HI, 32'd0);
    store(CMP_LO, 32'd20);
    store(CTRL, 32'd3);
    ld("cnt_start", MTIME_LO, 32'd0);
    repeat (20) tick();
    ld("cnt_at20", MTIME_LO, 32'd20);
    ld("pend_before", STATUS, 32'd0);
    chk("irq_before", {31'd0, timer_irq}, 32'h0);
    tick();
    ld("pend_set", STATUS, 32'd1);
    chk("irq_set", {31'd0, timer_irq}, 32'h1);
    ld("cnt_at21", MTIME_LO, 32'd21);
    store(STATUS, 32'd1);
    ld("set_beats_clr", STATUS, 32'd1);
    store(CTRL, 32'd2);
    tick();
    ld("cnt_stopped", MTIME_LO, 32'd23);
    chk("irq_en_only", {31'd0, timer_irq}, 32'h1);
    store(CMP_HI, 32'd1);
    store(STATUS, 32'd1);
    ld("pend_cleared", STATUS, 32'd0);
    chk("irq_cleared", {31'd0, timer_irq}, 32'h0);
    store(CMP_HI, 32'd0);
    ld("cmp_lower_lag", STATUS, 32'd0);
    tick();
    ld("cmp_lower_set", STATUS, 32'd1);
    chk("cmp_lower_irq", {31'd0, timer_irq}, 32'h1);

    // 64-bit wrap and write-over-increment precedence.
    store(CTRL, 32'd1);
    store(MTIME_HI, 32'hFFFF_FFFF);
    store(MTIME_LO, 32'hFFFF_FFFE);
    ld("wr_lo_no_inc", MTIME_LO, 32'hFFFF_FFFE);
    ld("wr_hi_held", MTIME_HI, 32'hFFFF_FFFF);
    chk("irq_masked", {31'd0, timer_irq}, 32'h0);
    tick();
    ld("wrap_max_lo", MTIME_LO, 32'hFFFF_FFFF);
    tick();
    ld("wrap_zero_lo", MTIME_LO, 32'h0);
    ld("wrap_zero_hi", MTIME_HI, 32'h0);
    tick();
    ld("wrap_one", MTIME_LO, 32'd1);

    // Asynchronous reset in the middle of counting with an interrupt pending.
    store(CTRL, 32'd0);
    store(MTIME_HI, 32'd0);
    store(MTIME_LO, 32'd95);
    store(CTRL, 32'd3);
    ld("pre_rst_95", MTIME_LO, 32'd95);
    repeat (5) tick();
    ld("pre_rst_100", MTIME_LO, 32'd100);
    chk("pre_rst_irq", {31'd0, timer_irq}, 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_irq_async", {31'd0, timer_irq}, 32'h0);
    ld("rst_ctrl", CTRL, 32'd0);
    ld("rst_mtime", MTIME_LO, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    ld("post_mtime", MTIME_LO, 32'd0);
    ld("post_ctrl", CTRL, 32'd0);
    ld("post_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
    ld("post_status", STATUS, 32'd0);
    chk("post_irq", {31'd0, timer_irq}, 32'h0);
    tick();
    ld("ram_keep_10", 32'h10, 32'hBEEF_11A5);
    ld("ram_keep_ffc", 32'hFFC, 32'hCAFE_BABE);
    ld("ram_keep_04", 32'h04, 32'h1122_3344);
    tick();
    store(CTRL, 32'd1);
    ld("first_cnt_0", MTIME_LO, 32'd0);
    tick();
    ld("first_cnt_1", MTIME_LO, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
